// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter that lends one shared 4-operand
// adder to NREQ requesters, one operation at a time.
// Optional feature: define ADDER_SCHED_OVCNT_EN to build the saturating
// 8-bit overflow event counter on ov_cnt; otherwise ov_cnt is tied to 0.
//
// Result handshake: res_valid rises with a new result and then holds, together
// with res_id/res_sum/res_ov, until a rising edge samples res_ready=1. That
// edge is the transfer. The handshake never drops res_valid without one.
module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*4*W-1:0]       opnd,
  output logic [NREQ-1:0]           gnt,
  output logic [W-1:0]              add_a,
  output logic [W-1:0]              add_b,
  output logic [W-1:0]              add_c,
  output logic [W-1:0]              add_d,
  input  logic [W-1:0]              add_sum,
  input  logic                      add_ov,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [W-1:0]              res_sum,
  output logic                      res_ov,
  output logic [7:0]                ov_cnt,
  output logic [1:0]                dbg_state
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;
  logic [4*W-1:0]  r_opnd;
  logic            r_res_valid;
  logic [IW-1:0]   r_res_id;
  logic [W-1:0]    r_res_sum;
  logic            r_res_ov;

  logic            w_found;
  logic [IW:0]     w_sh;
  logic [NREQ-1:0] w_rot;
  logic [IW:0]     w_off;
  logic [IW:0]     w_abs;
  logic [IW-1:0]   w_win;
  logic [4*W-1:0]  w_sel_opnd;

  // Rotate req so the bit after ptr sits at position 0, take the lowest set bit.
  always_comb begin
    w_found = |req;
    w_sh    = {1'b0, r_ptr} + 1'b1;
    w_rot   = NREQ'({req, req} >> w_sh);
    w_off   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = (IW + 1)'(j);
    end
    w_abs = w_sh + w_off;
    if (w_abs >= (IW + 1)'(NREQ)) w_abs = w_abs - (IW + 1)'(NREQ);
    w_win = IW'(w_abs);
  end

  // Operand slice of the arbitration winner.
  always_comb begin
    w_sel_opnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) w_sel_opnd = opnd[i*4*W +: 4*W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, grant pulse and adder operand drive.
  always_comb begin
    w_next = r_state;
    gnt    = '0;
    add_a  = '0;
    add_b  = '0;
    add_c  = '0;
    add_d  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        gnt    = NREQ'(1) << r_win;
        add_a  = r_opnd[4*W-1 -: W];
        add_b  = r_opnd[3*W-1 -: W];
        add_c  = r_opnd[2*W-1 -: W];
        add_d  = r_opnd[W-1:0];
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch winner/operands on selection, capture adder result on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= IW'(NREQ - 1);
      r_win       <= '0;
      r_opnd      <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_sum   <= '0;
      r_res_ov    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win  <= w_win;
            r_opnd <= w_sel_opnd;
          end
        end
        S_ISSUE: begin
          r_res_sum   <= add_sum;
          r_res_ov    <= add_ov;
          r_res_id    <= r_win;
          r_res_valid <= 1'b1;
          r_ptr       <= r_win;
        end
        S_HOLD: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SCHED_OVCNT_EN
  logic [7:0] r_ov_cnt;

  // Count overflowing issues, sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  r_ov_cnt <= 8'd0;
    else if (r_state == S_ISSUE && add_ov && r_ov_cnt != 8'hFF) r_ov_cnt <= r_ov_cnt + 8'd1;
  end

  assign ov_cnt = r_ov_cnt;
`else
  assign ov_cnt = 8'd0;
`endif

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_sum   = r_res_sum;
  assign res_ov    = r_res_ov;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/adder reference model.
module tb_adder_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IW   = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [NREQ-1:0]     req = '0;
  logic [NREQ*4*W-1:0] opnd = '0;
  logic                res_ready = 1'b1;
  logic [NREQ-1:0]     gnt;
  logic [W-1:0]        add_a, add_b, add_c, add_d, add_sum;
  logic                add_ov, res_valid, res_ov;
  logic [IW-1:0]       res_id;
  logic [W-1:0]        res_sum;
  logic [7:0]          ov_cnt;
  logic [1:0]          dbg_state;

  // Shared adder seen by the scheduler.
  logic [W+1:0] adder_tot;
  assign adder_tot = {2'b0, add_a} + {2'b0, add_b} + {2'b0, add_c} + {2'b0, add_d};
  assign add_sum   = adder_tot[W-1:0];
  assign add_ov    = |adder_tot[W+1:W];

  adder_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .opnd(opnd), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .add_sum(add_sum), .add_ov(add_ov),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_ov(res_ov), .ov_cnt(ov_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [IW+W:0] exp_q[$];
  int m_ptr = NREQ - 1;
  int m_ov  = 0;
  int last_gnt_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requester closest after the last winner, walking upward with wrap.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int best = -1;
    int bd   = 2 * NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        int d;
        d = (i - p - 1 + 2 * NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic int exp_ov_cnt();
`ifdef ADDER_SCHED_OVCNT_EN
    return (m_ov > 255) ? 255 : m_ov;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_opnd();
    for (int i = 0; i < NREQ; i++) opnd[i*4*W +: 4*W] = (4*W)'($urandom);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // idle cycle that follows the completed transfer.
  task automatic run_txn(input logic [NREQ-1:0] rv, input int stall, input bit drop, output int won);
    logic [4*W-1:0] sl;
    int a, b, c, d, tot;
    logic [IW+W:0] e;
    req = rv;
    won = pick(rv, m_ptr);
    sl  = opnd[won*4*W +: 4*W];
    a = int'(sl[4*W-1 -: W]); b = int'(sl[3*W-1 -: W]);
    c = int'(sl[2*W-1 -: W]); d = int'(sl[W-1:0]);
    tot = a + b + c + d;
    exp_q.push_back({IW'(won), tot >= (1 << W), W'(tot % (1 << W))});
    if (tot >= (1 << W)) m_ov++;
    @(posedge clk); @(negedge clk);
    check("gnt", gnt, 1 << won);
    check("add_a", add_a, a); check("add_b", add_b, b);
    check("add_c", add_c, c); check("add_d", add_d, d);
    last_gnt_cyc = cyc;
    rand_opnd();
    if (drop) req[won] = 1'b0;
    #1 check("add_a_latched", add_a, a);
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    check("res_valid", res_valid, 1); check("gnt_hold", gnt, 0);
    check("res_id", res_id, e[IW+W:W+1]); check("res_ov", res_ov, e[W]);
    check("res_sum", res_sum, e[W-1:0]); check("add_a_hold", add_a, 0);
    check("ov_cnt", ov_cnt, exp_ov_cnt());
    if (stall > 0) begin
      res_ready = 1'b0;
      repeat (stall) begin
        @(posedge clk); @(negedge clk);
        check("stall_valid", res_valid, 1); check("stall_gnt", gnt, 0);
        check("stall_sum", res_sum, e[W-1:0]); check("stall_id", res_id, e[IW+W:W+1]);
        check("stall_ov", res_ov, e[W]);
      end
      res_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check("valid_drop", res_valid, 0); check("gnt_idle", gnt, 0);
    m_ptr = won;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int won;
    int order [5];
    int prev;
    order = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 0); check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0); check("rst_id", res_id, 0);
    check("rst_ov", res_ov, 0); check("rst_ovcnt", ov_cnt, 0);
    check("rst_add", {add_a, add_b, add_c, add_d}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", gnt, 0);

    // Fairness with all requesters held high.
    rand_opnd();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b1111, 0, 1'b0, won);
      check("fair_order", won, order[k]);
      if (k > 0) check("fair_rate", last_gnt_cyc - prev, 3);
      prev = last_gnt_cyc;
    end
    req = '0;
    @(negedge clk);

    // Single request 3+4+5+2.
    opnd[15:0] = 16'h3452;
    run_txn(4'b0001, 0, 1'b1, won);
    // Overflow 15*4.
    for (int i = 0; i < NREQ; i++) opnd[i*4*W +: 4*W] = '1;
    run_txn(4'b0001, 0, 1'b1, won);
    check("ovcnt_after_one", ov_cnt, exp_ov_cnt());

    // Backpressure with other requesters waiting.
    rand_opnd();
    run_txn(4'b1010, 5, 1'b0, won);
    req = '0;

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      rand_opnd();
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3), 1'($urandom), won);
    end
    req = '0;
    @(negedge clk);

    // Reset during ISSUE aborts the operation.
    rand_opnd();
    req = 4'b0010;
    @(posedge clk); @(negedge clk);
    check("pre_rst_gnt", gnt, 1 << pick(4'b0010, m_ptr));
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 0); check("mid_rst_add", {add_a, add_b, add_c, add_d}, 0);
    check("mid_rst_valid", res_valid, 0); check("mid_rst_id", res_id, 0);
    check("mid_rst_sum", res_sum, 0); check("mid_rst_ov", res_ov, 0);
    check("mid_rst_ovcnt", ov_cnt, 0);
    req = '0;
    m_ptr = NREQ - 1;
    m_ov  = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("post_rst_valid", res_valid, 0); check("post_rst_gnt", gnt, 0);
    end
    run_txn(4'b0100, 0, 1'b1, won);
    check("post_rst_winner", won, 2);

    // Saturation of the overflow counter.
    for (int i = 0; i < NREQ; i++) opnd[i*4*W +: 4*W] = '1;
    for (int k = 0; k < 300; k++) run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 0, 1'b0, won);
    req = '0;
    @(negedge clk);
`ifdef ADDER_SCHED_OVCNT_EN
    check("ovcnt_sat", ov_cnt, 255);
`else
    check("ovcnt_off", ov_cnt, 0);
`endif
    check("ovcnt_model", ov_cnt, exp_ov_cnt());
    check("queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
